// File: rtl/mem_access_stage_if.sv
// Bus bundle between the execute stage, the memory-access stage, DMEM and
// the register-file writeback stage. The stage connects through the slave
// modport; whatever drives the execute side and models DMEM uses master.
interface mem_access_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_load;
  logic              ex_store;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [RD_W-1:0]   ex_rd;

  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_data;
  logic              dmem_ctrl_rd;
  logic              dmem_ctrl_wrt;
  logic [DATA_W-1:0] dmem_rd_data;

  logic              wb_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;

  logic              op_err;
  logic [DATA_W-1:0] mmio_out;

  modport master (
    output ex_valid, ex_load, ex_store, ex_addr, ex_wdata, ex_rd,
    output dmem_rd_data, wb_ready,
    input  ex_ready, dmem_addr, dmem_data, dmem_ctrl_rd, dmem_ctrl_wrt,
    input  wb_valid, wb_data, wb_rd, op_err, mmio_out
  );

  modport slave (
    input  ex_valid, ex_load, ex_store, ex_addr, ex_wdata, ex_rd,
    input  dmem_rd_data, wb_ready,
    output ex_ready, dmem_addr, dmem_data, dmem_ctrl_rd, dmem_ctrl_wrt,
    output wb_valid, wb_data, wb_rd, op_err, mmio_out
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: one load/store/passthrough op at a time, one-cycle
// DMEM strobes, held writeback result.
// Optional feature: define MEM_STAGE_MMIO_EN to map address all-ones to the
// mmio_out register instead of DMEM; otherwise mmio_out is tied to 0.
//
// state | meaning
// IDLE  | ex_ready high, waiting for an op
// LOAD  | dmem_ctrl_rd strobe cycle, read data captured at its closing edge
// STORE | dmem_ctrl_wrt strobe cycle, returns to IDLE
// WB    | wb_valid high, result held until wb_ready
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_access_stage_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, WB} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_valid_q;
  logic              ctrl_rd_q;
  logic              ctrl_wrt_q;
  logic              op_err_q;
  logic [DATA_W-1:0] mmio_q;
  logic              ex_hit;
  logic              addr_hit;

`ifdef MEM_STAGE_MMIO_EN
  assign ex_hit   = (bus.ex_addr == {ADDR_W{1'b1}});
  assign addr_hit = (addr_q == {ADDR_W{1'b1}});

  // MMIO register captures store data at the closing edge of STORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mmio_q <= '0;
    end else if (state == STORE && addr_hit) begin
      mmio_q <= data_q;
    end
  end
`else
  assign ex_hit   = 1'b0;
  assign addr_hit = 1'b0;
  assign mmio_q   = '0;
`endif

  // Sequencer: state plus every registered output the stage presents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      ctrl_rd_q  <= 1'b0;
      ctrl_wrt_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            if (bus.ex_load && bus.ex_store) begin
              // Ambiguous op is dropped without touching the holding regs.
              op_err_q <= 1'b1;
            end else begin
              addr_q <= bus.ex_addr;
              data_q <= bus.ex_wdata;
              rd_q   <= bus.ex_rd;
              if (bus.ex_load) begin
                state     <= LOAD;
                ctrl_rd_q <= !ex_hit;
              end else if (bus.ex_store) begin
                state      <= STORE;
                ctrl_wrt_q <= !ex_hit;
              end else begin
                state      <= WB;
                wb_data_q  <= DATA_W'(bus.ex_addr);
                wb_valid_q <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          ctrl_rd_q  <= 1'b0;
          wb_data_q  <= addr_hit ? mmio_q : bus.dmem_rd_data;
          wb_valid_q <= 1'b1;
          state      <= WB;
        end
        STORE: begin
          ctrl_wrt_q <= 1'b0;
          state      <= IDLE;
        end
        WB: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          ctrl_rd_q  <= 1'b0;
          ctrl_wrt_q <= 1'b0;
          wb_valid_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.ex_ready      = (state == IDLE);
  assign bus.dmem_addr     = addr_q;
  assign bus.dmem_data     = data_q;
  assign bus.dmem_ctrl_rd  = ctrl_rd_q;
  assign bus.dmem_ctrl_wrt = ctrl_wrt_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.wb_rd         = rd_q;
  assign bus.op_err        = op_err_q;
  assign bus.mmio_out      = mmio_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writeback
// results and DMEM writes; a monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if #(.ADDR_W(8), .DATA_W(8), .RD_W(3)) bus ();

  mem_access_stage #(.ADDR_W(8), .DATA_W(8), .RD_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef MEM_STAGE_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  // DMEM model: combinational read, write on rising edge.
  logic [7:0] dmem [256];
  assign bus.dmem_rd_data = dmem[bus.dmem_addr];
  always @(posedge clk) if (bus.dmem_ctrl_wrt) dmem[bus.dmem_addr] <= bus.dmem_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] wb_q [$];   // {rd, data}
  logic [15:0] wr_q [$];   // {addr, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes writeback handshakes and DMEM writes away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.wb_valid && bus.wb_ready) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 1, 0);
        else begin
          logic [10:0] e;
          e = wb_q.pop_front();
          chk("wb_data", bus.wb_data, e[7:0]);
          chk("wb_rd", bus.wb_rd, e[10:8]);
        end
      end
      if (rst_n && bus.dmem_ctrl_wrt) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          logic [15:0] w;
          w = wr_q.pop_front();
          chk("wr_addr", bus.dmem_addr, w[15:8]);
          chk("wr_data", bus.dmem_data, w[7:0]);
        end
      end
      if (bus.dmem_ctrl_rd && bus.dmem_ctrl_wrt) chk("strobe_overlap", 1, 0);
    end
  end

  // Issue one op; called #1 after a rising edge, returns #1 after the accept edge.
  task automatic issue(input logic l, input logic s, input logic [7:0] a,
                       input logic [7:0] wd, input logic [2:0] rd);
    int n = 0;
    while (!bus.ex_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.ex_ready) chk("ready_timeout", 0, 1);
    bus.ex_valid = 1'b1; bus.ex_load = l; bus.ex_store = s;
    bus.ex_addr = a; bus.ex_wdata = wd; bus.ex_rd = rd;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0; bus.ex_load = 1'b0; bus.ex_store = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    bus.ex_valid = 0; bus.ex_load = 0; bus.ex_store = 0;
    bus.ex_addr = 0; bus.ex_wdata = 0; bus.ex_rd = 0; bus.wb_ready = 1'b1;
    #12;
    chk("rst_ex_ready", bus.ex_ready, 1);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_ctrl", {bus.dmem_ctrl_rd, bus.dmem_ctrl_wrt}, 0);
    chk("rst_op_err", bus.op_err, 0);
    chk("rst_mmio", bus.mmio_out, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step();

    // Store then load from 8'h10.
    wr_q.push_back({8'h10, 8'h5A});
    issue(0, 1, 8'h10, 8'h5A, 3'd0);
    chk("st_wrt_high", bus.dmem_ctrl_wrt, 1);
    chk("st_ready_low", bus.ex_ready, 0);
    step();
    chk("st_wrt_low", bus.dmem_ctrl_wrt, 0);
    chk("st_ready_back", bus.ex_ready, 1);

    wb_q.push_back({3'd3, 8'h5A});
    issue(1, 0, 8'h10, 8'h00, 3'd3);
    chk("ld_rd_high", bus.dmem_ctrl_rd, 1);
    chk("ld_wbv_low", bus.wb_valid, 0);
    step();
    chk("ld_rd_low", bus.dmem_ctrl_rd, 0);
    chk("ld_wbv_high", bus.wb_valid, 1);
    step();
    chk("ld_idle", bus.ex_ready, 1);
    chk("ld_wbv_fall", bus.wb_valid, 0);

    // Passthrough.
    wb_q.push_back({3'd5, 8'h2C});
    issue(0, 0, 8'h2C, 8'h77, 3'd5);
    chk("pt_wbv", bus.wb_valid, 1);
    chk("pt_data", bus.wb_data, 8'h2C);
    chk("pt_strobes", {bus.dmem_ctrl_rd, bus.dmem_ctrl_wrt}, 0);
    step();
    chk("pt_idle", bus.ex_ready, 1);

    // Back-to-back stores, then loads back.
    wr_q.push_back({8'h20, 8'hC3});
    issue(0, 1, 8'h20, 8'hC3, 3'd0);
    wr_q.push_back({8'h21, 8'h3C});
    issue(0, 1, 8'h21, 8'h3C, 3'd0);
    wb_q.push_back({3'd1, 8'h3C});
    issue(1, 0, 8'h21, 8'h00, 3'd1);
    wb_q.push_back({3'd2, 8'hC3});
    issue(1, 0, 8'h20, 8'h00, 3'd2);
    step(); step();

    // Backpressure on a load.
    bus.wb_ready = 1'b0;
    wb_q.push_back({3'd6, 8'hC3});
    issue(1, 0, 8'h20, 8'h00, 3'd6);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("bp_wbv", bus.wb_valid, 1);
      chk("bp_data", bus.wb_data, 8'hC3);
      chk("bp_rd", bus.wb_rd, 3'd6);
      chk("bp_ready", bus.ex_ready, 0);
      step();
    end
    bus.wb_ready = 1'b1;
    step();
    chk("bp_release", bus.ex_ready, 1);
    chk("bp_wbv_low", bus.wb_valid, 0);

    // Illegal op.
    issue(1, 1, 8'h30, 8'h99, 3'd7);
    chk("ill_err", bus.op_err, 1);
    chk("ill_ready", bus.ex_ready, 1);
    chk("ill_wbv", bus.wb_valid, 0);
    chk("ill_strobes", {bus.dmem_ctrl_rd, bus.dmem_ctrl_wrt}, 0);
    wb_q.push_back({3'd4, 8'h11});
    issue(0, 0, 8'h11, 8'h00, 3'd4);
    step();
    chk("ill_sticky", bus.op_err, 1);

    // Store/load at 8'hFF.
    if (!MMIO) wr_q.push_back({8'hFF, 8'hA5});
    issue(0, 1, 8'hFF, 8'hA5, 3'd0);
    chk("ff_st_wrt", bus.dmem_ctrl_wrt, !MMIO);
    step();
    chk("ff_mmio", bus.mmio_out, MMIO ? 8'hA5 : 8'h00);
    wb_q.push_back({3'd4, 8'hA5});
    issue(1, 0, 8'hFF, 8'h00, 3'd4);
    chk("ff_ld_rd", bus.dmem_ctrl_rd, !MMIO);
    step();
    chk("ff_ld_wbv", bus.wb_valid, 1);
    step();

    // Reset during LOAD.
    issue(1, 0, 8'h10, 8'h00, 3'd2);
    chk("rl_rd_high", bus.dmem_ctrl_rd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_rd_low", bus.dmem_ctrl_rd, 0);
    chk("rl_wbv", bus.wb_valid, 0);
    chk("rl_ready", bus.ex_ready, 1);
    chk("rl_err_clr", bus.op_err, 0);
    chk("rl_mmio_clr", bus.mmio_out, 0);
    @(posedge clk); #1;
    chk("rl_wbv_hold", bus.wb_valid, 0);
    rst_n = 1'b1;
    step();
    chk("rl_dmem_kept", dmem[8'h10], 8'h5A);

    step(); step();
    chk("wb_q_empty", wb_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
